wb_burst_to_classic: RTL and testbench
======================================

Name: wb_burst_to_classic

Overview:
- Downstream neighbour of the memory-side bus master (wb_mem); consumes its pipelined burst interface (address, burstcount, waitrequest, readdatavalid) and converts it into classic registered-feedback Wishbone B4 cycles (cyc/stb/ack, CTI/BTE) for the system bus.
- Each burst of 1..4 dwords becomes one CYC with incrementing-address beats.
- Adds a per-beat ack watchdog so a dead slave cannot hang the CPU.

Parameters:
- TIMEOUT, 255, cycles to wait for wb_ack_i/wb_err_i on one beat before a forced error termination; 0 disables the watchdog; legal range 0..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mem_address_i  in  32  burst start address, bits [1:0] ignored
- mem_writedata_i  in  32  write data for the current beat
- mem_byteenable_i  in  4  byte enables for the current beat
- mem_burstcount_i  in  3  beats in burst, 1..4
- mem_write_i  in  1  write burst request, held until the last beat is accepted
- mem_read_i  in  1  read command request
- mem_waitrequest_o  out  1  stall to upstream
- mem_readdatavalid_o  out  1  one read beat returned
- mem_readdata_o  out  32  read beat data
- wb_adr_o  out  32  Wishbone address, bits [1:0]=0
- wb_dat_o  out  32  Wishbone write data
- wb_sel_o  out  4  Wishbone byte select
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_cti_o  out  3  010 incrementing, 111 end-of-burst
- wb_bte_o  out  2  always 00 (linear)
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  beat acknowledge
- wb_err_i  in  1  beat error
- bus_error_o  out  1  one-cycle pulse per errored or timed-out beat

Behaviour:
- Reset (async, rst_n low): state IDLE; cyc, stb, we, readdatavalid, bus_error_o = 0; adr, readdata = 0; cti = 000; counters = 0. Reset mid-burst aborts immediately; no completion is reported upstream.
- States: IDLE, WRITE, READ.
- mem_waitrequest_o is combinational:
  - IDLE: 0 when mem_read_i is high and mem_write_i is low; 1 otherwise.
  - WRITE: equals ~(wb_ack_i | wb_err_i | timeout).
  - READ: 1.
- IDLE with mem_write_i high (write has priority over a simultaneous read):
  - Latch adr = {addr[31:2],2'b00} and remaining = burstcount; burstcount 0 is treated as 1, values >4 are clamped to 4.
  - Next cycle: cyc = stb = we = 1; go to WRITE.
- WRITE:
  - wb_dat_o and wb_sel_o pass mem_writedata_i and mem_byteenable_i through combinationally.
  - On ack, err or timeout: the beat is consumed; adr += 4; remaining -= 1.
  - When the final beat is consumed, drop cyc/stb/we in the next cycle and return to IDLE.
- IDLE with mem_read_i high (and mem_write_i low):
  - Command accepted in the same cycle (waitrequest 0).
  - Latch address and count as for writes; next cycle cyc = stb = 1, we = 0; go to READ.
- READ:
  - Each ack/err/timeout beat: mem_readdata_o <= wb_dat_i, or 32'hFFFF_FFFF on timeout; mem_readdatavalid_o pulses the following cycle, so latency is 1 cycle after ack.
  - adr += 4 per beat. After the last beat: cyc/stb drop, return to IDLE.
  - Exactly burstcount readdatavalid pulses are produced per command.
- wb_cti_o: 111 when remaining == 1, else 010; held 000 in IDLE.
- Address increment is linear 32-bit and wraps at 32'hFFFF_FFFC to 0; there is no line wrap.
- Watchdog:
  - 8-bit counter cleared at each beat start and on ack/err.
  - When it reaches TIMEOUT with stb high and no ack, the beat terminates as if err.
  - ack and err in the same cycle count as err.
- bus_error_o pulses the cycle after each err/timeout beat. A burst always runs to completion; an error does not cut it short.
- mem_*_i are ignored outside IDLE, except write data and byteenable in WRITE.

Test Plan:
- Write burst, addr 0x1000, burstcount 4, ack every cycle -> wb_adr sequence 0x1000/04/08/0C; cti 010,010,010,111; 4 upstream waitrequest-low cycles; cyc low 1 cycle after the 4th ack.
- Read burstcount 3 at 0x2006, slave acks with 0xA,0xB,0xC after 2 wait cycles each -> wb_adr 0x2004/08/0C; 3 readdatavalid pulses, each one cycle after its ack, carrying A,B,C.
- mem_write_i and mem_read_i high together in IDLE -> write serviced first; read waitrequest stays 1 until the write completes, then the read is accepted.
- TIMEOUT=8, read burstcount 1, slave never acks -> after 8 cycles, readdata 0xFFFF_FFFF, readdatavalid and bus_error_o each pulse once, cyc drops.
- wb_err_i on beat 2 of a 4-beat write -> bus_error_o pulses once; beats 3 and 4 still issued; upstream sees 4 accepted beats.
- rst_n asserted mid-read (beat 2 of 4) -> cyc/stb/readdatavalid go 0 immediately; after release, state is IDLE and a new read of 0x3000 completes normally.

Source files
------------

// File: rtl/wb_burst_to_classic.sv
// rtl/wb_burst_to_classic.sv - pipelined burst master port to classic Wishbone B4 cycles
// One CYC per burst, incrementing CTI beats, per-beat ack watchdog.
module wb_burst_to_classic #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_address_i,
  input  logic [31:0] mem_writedata_i,
  input  logic [3:0]  mem_byteenable_i,
  input  logic [2:0]  mem_burstcount_i,
  input  logic        mem_write_i,
  input  logic        mem_read_i,
  output logic        mem_waitrequest_o,
  output logic        mem_readdatavalid_o,
  output logic [31:0] mem_readdata_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_error_o
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [2:0]  rem_q, rem_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        rdv_q, rdv_d;
  logic [31:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;

  logic [2:0]  burst_len;
  logic        timeout;
  logic        beat_done;
  logic        unused_adr_lsbs;

  assign unused_adr_lsbs = ^mem_address_i[1:0];

  always_comb begin
    burst_len = mem_burstcount_i;
    if (mem_burstcount_i == 3'd0) begin
      burst_len = 3'd1;
    end else if (mem_burstcount_i > 3'd4) begin
      burst_len = 3'd4;
    end
  end

  // A simultaneous ack/err always wins over the watchdog, so a late ack is never turned into an error.
  assign timeout   = (TIMEOUT != 0) && cyc_q && !wb_ack_i && !wb_err_i && (wdog_q == TIMEOUT_CNT);
  assign beat_done = cyc_q && (wb_ack_i || wb_err_i || timeout);

  always_comb begin
    state_d           = state_q;
    adr_d             = adr_q;
    rem_d             = rem_q;
    cyc_d             = cyc_q;
    we_d              = we_q;
    wdog_d            = wdog_q;
    rdv_d             = 1'b0;
    rdata_d           = rdata_q;
    berr_d            = 1'b0;
    mem_waitrequest_o = 1'b1;

    case (state_q)
      IDLE: begin
        mem_waitrequest_o = !(mem_read_i && !mem_write_i);
        wdog_d            = 8'd0;
        if (mem_write_i || mem_read_i) begin
          adr_d   = {mem_address_i[31:2], 2'b00};
          rem_d   = burst_len;
          cyc_d   = 1'b1;
          we_d    = mem_write_i;
          state_d = mem_write_i ? WRITE : READ;
        end
      end
      WRITE, READ: begin
        if (state_q == WRITE) begin
          mem_waitrequest_o = !beat_done;
        end
        if (beat_done) begin
          adr_d  = adr_q + 32'd4;
          rem_d  = rem_q - 3'd1;
          wdog_d = 8'd0;
          berr_d = wb_err_i || timeout;
          if (state_q == READ) begin
            rdv_d   = 1'b1;
            rdata_d = timeout ? 32'hFFFF_FFFF : wb_dat_i;
          end
          if (rem_q == 3'd1) begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            state_d = IDLE;
          end
        end else if (wdog_q != 8'hFF) begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= 32'd0;
      rem_q   <= 3'd0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      wdog_q  <= 8'd0;
      rdv_q   <= 1'b0;
      rdata_q <= 32'd0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      wdog_q  <= wdog_d;
      rdv_q   <= rdv_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
    end
  end

  assign wb_adr_o            = adr_q;
  assign wb_dat_o            = mem_writedata_i;
  assign wb_sel_o            = mem_byteenable_i;
  assign wb_we_o             = we_q;
  assign wb_cyc_o            = cyc_q;
  assign wb_stb_o            = cyc_q;
  assign wb_cti_o            = !cyc_q ? 3'b000 : ((rem_q == 3'd1) ? 3'b111 : 3'b010);
  assign wb_bte_o            = 2'b00;
  assign mem_readdatavalid_o = rdv_q;
  assign mem_readdata_o      = rdata_q;
  assign bus_error_o         = berr_q;

endmodule

// File: tb/tb_wb_burst_to_classic.sv
// tb/tb_wb_burst_to_classic.sv - self-checking bench for wb_burst_to_classic
module tb_wb_burst_to_classic;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_address_i, mem_writedata_i;
  logic [3:0]  mem_byteenable_i;
  logic [2:0]  mem_burstcount_i;
  logic        mem_write_i, mem_read_i;
  logic        mem_waitrequest_o, mem_readdatavalid_o;
  logic [31:0] mem_readdata_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;
  logic        bus_error_o;

  wb_burst_to_classic #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_address_i(mem_address_i), .mem_writedata_i(mem_writedata_i),
    .mem_byteenable_i(mem_byteenable_i), .mem_burstcount_i(mem_burstcount_i),
    .mem_write_i(mem_write_i), .mem_read_i(mem_read_i),
    .mem_waitrequest_o(mem_waitrequest_o), .mem_readdatavalid_o(mem_readdatavalid_o),
    .mem_readdata_o(mem_readdata_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .bus_error_o(bus_error_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Slave plan per beat: resp 0=ack 1=err 2=never respond 3=ack+err
  int          dly[4];
  int          resp[4];
  logic [31:0] sdata[4];
  logic [31:0] wdata[4];
  logic [3:0]  wsel[4];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          bc;
    int          dly;
    int          err_beat;
    int          none_beat;
    logic [31:0] d0;
    int          exp_beats;
    int          exp_errs;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one burst from the IDLE cycle in which it is requested; returns beats seen upstream and error pulses.
  task automatic do_burst(input bit wr, input logic [31:0] a, input int bc, input bit hold_rd,
                          output int beats, output int errs);
    int n, beat, waitc, guard, r;
    bit done, tmo, pend_rd, pend_err;
    logic [31:0] pend_data, eadr;
    n     = (bc == 0) ? 1 : ((bc > 4) ? 4 : bc);
    eadr  = {a[31:2], 2'b00};
    beats = 0; errs = 0; beat = 0; waitc = 0; guard = 0;
    pend_rd = 1'b0; pend_err = 1'b0; pend_data = 32'd0;
    mem_address_i    = a;
    mem_burstcount_i = 3'(bc);
    mem_writedata_i  = wdata[0];
    mem_byteenable_i = wsel[0];
    mem_write_i      = wr;
    mem_read_i       = !wr || hold_rd;
    #1;
    chk("req_waitrequest", 32'(mem_waitrequest_o), 32'(wr));
    @(posedge clk); #1;
    if (!wr) begin
      mem_read_i       = 1'b0;
      mem_address_i    = $urandom;
      mem_burstcount_i = 3'($urandom_range(0, 7));
    end
    while (beat < n && guard < 200) begin
      r = (resp[beat] != 2 && waitc == dly[beat]) ? resp[beat] : 2;
      wb_ack_i = (r == 0) || (r == 3);
      wb_err_i = (r == 1) || (r == 3);
      wb_dat_i = (r != 2) ? sdata[beat] : $urandom;
      tmo  = (r == 2) && (waitc == TO);
      done = (r != 2) || tmo;
      #1;
      chk("cyc", 32'(wb_cyc_o), 32'd1);
      chk("stb", 32'(wb_stb_o), 32'd1);
      chk("we", 32'(wb_we_o), 32'(wr));
      chk("adr", wb_adr_o, eadr);
      chk("cti", 32'(wb_cti_o), (beat == n - 1) ? 32'd7 : 32'd2);
      chk("bte", 32'(wb_bte_o), 32'd0);
      if (wr) begin
        chk("wr_dat", wb_dat_o, wdata[beat]);
        chk("wr_sel", 32'(wb_sel_o), 32'(wsel[beat]));
        chk("wr_waitrequest", 32'(mem_waitrequest_o), 32'(!done));
        if (!mem_waitrequest_o) beats++;
      end else begin
        chk("rd_waitrequest", 32'(mem_waitrequest_o), 32'd1);
      end
      chk("rdv", 32'(mem_readdatavalid_o), 32'(pend_rd));
      if (pend_rd) chk("rdata", mem_readdata_o, pend_data);
      if (mem_readdatavalid_o) beats++;
      chk("bus_error", 32'(bus_error_o), 32'(pend_err));
      if (bus_error_o) errs++;
      pend_rd   = done && !wr;
      pend_data = tmo ? 32'hFFFF_FFFF : sdata[beat];
      pend_err  = done && (wb_err_i || tmo);
      @(posedge clk); #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (done) begin
        beat++;
        waitc = 0;
        eadr  = eadr + 32'd4;
        if (beat < n) begin
          mem_writedata_i  = wdata[beat];
          mem_byteenable_i = wsel[beat];
        end else begin
          mem_write_i = 1'b0;
        end
      end else begin
        waitc++;
      end
      guard++;
    end
    if (guard >= 200) begin
      errors++;
      checks++;
      $display("FAIL burst_budget act=%0d beats exp=%0d", beat, n);
      mem_write_i = 1'b0;
    end
    #1;
    chk("end_cyc", 32'(wb_cyc_o), 32'd0);
    chk("end_stb", 32'(wb_stb_o), 32'd0);
    chk("end_we", 32'(wb_we_o), 32'd0);
    chk("end_cti", 32'(wb_cti_o), 32'd0);
    chk("end_rdv", 32'(mem_readdatavalid_o), 32'(pend_rd));
    if (pend_rd) chk("end_rdata", mem_readdata_o, pend_data);
    if (mem_readdatavalid_o) beats++;
    chk("end_bus_error", 32'(bus_error_o), 32'(pend_err));
    if (bus_error_o) errs++;
    chk("end_waitrequest", 32'(mem_waitrequest_o), (wr && hold_rd) ? 32'd0 : 32'd1);
  endtask

  task automatic plan(input int d, input int err_beat, input int none_beat, input logic [31:0] d0);
    for (int i = 0; i < 4; i++) begin
      dly[i]   = d;
      resp[i]  = (i == err_beat) ? 1 : ((i == none_beat) ? 2 : 0);
      sdata[i] = d0 + 32'(i);
      wdata[i] = $urandom;
      wsel[i]  = 4'($urandom);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int b, e, n, xe;
    bit wr;
    logic [31:0] a;
    int bc, r;

    vecs[0] = '{1'b1, 32'h0000_1000, 4, 0, -1, -1, 32'h0,   4, 0};
    vecs[1] = '{1'b0, 32'h0000_2006, 3, 2, -1, -1, 32'hA,   3, 0};
    vecs[2] = '{1'b0, 32'h0000_5000, 1, 0, -1,  0, 32'h0,   1, 1};
    vecs[3] = '{1'b1, 32'h0000_6000, 4, 1,  1, -1, 32'h0,   4, 1};
    vecs[4] = '{1'b1, 32'hFFFF_FFF8, 4, 0, -1, -1, 32'h0,   4, 0};
    vecs[5] = '{1'b0, 32'h0000_7000, 0, 1, -1, -1, 32'h55,  1, 0};
    vecs[6] = '{1'b1, 32'h0000_8000, 7, 3, -1, -1, 32'h0,   4, 0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 2, 0, -1,  1, 32'h77,  2, 1};

    rst_n = 1'b0;
    mem_address_i = 32'd0; mem_writedata_i = 32'd0; mem_byteenable_i = 4'd0;
    mem_burstcount_i = 3'd0; mem_write_i = 1'b0; mem_read_i = 1'b0;
    wb_dat_i = 32'd0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_rdv", 32'(mem_readdatavalid_o), 32'd0);
    chk("rst_bus_error", 32'(bus_error_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_rdata", mem_readdata_o, 32'd0);
    chk("rst_cti", 32'(wb_cti_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      plan(vecs[i].dly, vecs[i].err_beat, vecs[i].none_beat, vecs[i].d0);
      do_burst(vecs[i].wr, vecs[i].addr, vecs[i].bc, 1'b0, b, e);
      chk($sformatf("vec%0d_beats", i), 32'(b), 32'(vecs[i].exp_beats));
      chk($sformatf("vec%0d_errs", i), 32'(e), 32'(vecs[i].exp_errs));
    end

    // Write and read requested together: write goes first, read accepted right after.
    plan(1, -1, -1, 32'h100);
    do_burst(1'b1, 32'h0000_A000, 2, 1'b1, b, e);
    chk("both_wr_beats", 32'(b), 32'd2);
    plan(0, -1, -1, 32'h200);
    do_burst(1'b0, 32'h0000_B000, 2, 1'b0, b, e);
    chk("both_rd_beats", 32'(b), 32'd2);

    // Reset during beat 2 of a 4-beat read.
    mem_read_i = 1'b1; mem_address_i = 32'h0000_4000; mem_burstcount_i = 3'd4;
    @(posedge clk); #1;
    mem_read_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'h1234_5678;
    @(posedge clk); #1;
    wb_ack_i = 1'b0;
    #1;
    chk("pre_rst_rdv", 32'(mem_readdatavalid_o), 32'd1);
    chk("pre_rst_adr", wb_adr_o, 32'h0000_4004);
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("midrst_stb", 32'(wb_stb_o), 32'd0);
    chk("midrst_rdv", 32'(mem_readdatavalid_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    plan(0, -1, -1, 32'h3000_0000);
    do_burst(1'b0, 32'h0000_3000, 4, 1'b0, b, e);
    chk("post_rst_beats", 32'(b), 32'd4);
    chk("post_rst_errs", 32'(e), 32'd0);

    for (int k = 0; k < 40; k++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      bc = $urandom_range(0, 7);
      n  = (bc == 0) ? 1 : ((bc > 4) ? 4 : bc);
      xe = 0;
      for (int i = 0; i < 4; i++) begin
        dly[i]   = $urandom_range(0, 3);
        r        = $urandom_range(0, 19);
        resp[i]  = (r < 16) ? 0 : ((r < 18) ? 1 : ((r == 18) ? 3 : 2));
        sdata[i] = $urandom;
        wdata[i] = $urandom;
        wsel[i]  = 4'($urandom);
        if (i < n && resp[i] != 0) xe++;
      end
      do_burst(wr, a, bc, 1'($urandom_range(0, 1)), b, e);
      chk("rand_beats", 32'(b), 32'(n));
      chk("rand_errs", 32'(e), 32'(xe));
      if ($urandom_range(0, 1) == 1) begin
        mem_read_i = 1'b0;
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
